// File: rtl/l2_mshr_alloc.sv
`default_nettype none
// ============================================================================
// Module   : l2_mshr_alloc
// Purpose  : MSHR allocation/free tracker for the Spandex L2. It keeps a
//            valid bitmap plus tag/set per entry, grants the lowest free
//            entry, and answers tag/set lookups combinationally. It also
//            drives the add/incr/clear strobes consumed by l2_regs.
// Ports    : clk, rst (async, active-low)
//            alloc_req/alloc_tag/alloc_set -> alloc_gnt/alloc_idx
//            free_valid/free_idx           -> entry release
//            lookup_tag/lookup_set         -> lookup_hit/lookup_hit_idx/
//                                             lookup_set_conflict
//            add_mshr_entry, incr_mshr_cnt, lmem_wr_en_clear_mshr, mshr_i
//            full, empty, free_cnt
// Revision : 1.0 - initial release
// ============================================================================
module l2_mshr_alloc #(
  parameter int N_MSHR    = 16,
  parameter int MSHR_BITS = 4,
  parameter int SET_BITS  = 9,
  parameter int TAG_BITS  = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  input  logic [TAG_BITS-1:0]  alloc_tag,
  input  logic [SET_BITS-1:0]  alloc_set,
  output logic                 alloc_gnt,
  output logic [MSHR_BITS-1:0] alloc_idx,
  input  logic                 free_valid,
  input  logic [MSHR_BITS-1:0] free_idx,
  input  logic [TAG_BITS-1:0]  lookup_tag,
  input  logic [SET_BITS-1:0]  lookup_set,
  output logic                 lookup_hit,
  output logic [MSHR_BITS-1:0] lookup_hit_idx,
  output logic                 lookup_set_conflict,
  output logic                 add_mshr_entry,
  output logic                 incr_mshr_cnt,
  output logic                 lmem_wr_en_clear_mshr,
  output logic [MSHR_BITS-1:0] mshr_i,
  output logic                 full,
  output logic                 empty,
  output logic [MSHR_BITS:0]   free_cnt
);

  localparam logic [MSHR_BITS:0] C_CNT_ONE = (MSHR_BITS+1)'(1);
  localparam logic [MSHR_BITS:0] C_CNT_ALL = (MSHR_BITS+1)'(N_MSHR);

  logic [N_MSHR-1:0]    r_valid;
  logic [TAG_BITS-1:0]  r_tag [N_MSHR];
  logic [SET_BITS-1:0]  r_set [N_MSHR];
  // Releases not yet reported to l2_regs because an add won that cycle.
  logic [MSHR_BITS:0]   r_pend_incr;

  logic                 w_free_in_range;
  logic                 w_free_fire;
  logic                 w_alloc_gnt;
  logic                 w_incr;
  logic                 w_full;
  logic [MSHR_BITS:0]   w_free_cnt;
  logic [MSHR_BITS-1:0] w_alloc_idx;
  logic [N_MSHR-1:0]    w_valid_nxt;
  logic                 w_hit;
  logic [MSHR_BITS-1:0] w_hit_idx;
  logic                 w_conflict;

  // When the index width exactly covers the entry count every index is legal.
  generate
    if (N_MSHR == (1 << MSHR_BITS)) begin : g_full_range
      assign w_free_in_range = 1'b1;
    end else begin : g_part_range
      assign w_free_in_range = (int'(free_idx) < N_MSHR);
    end
  endgenerate

  // Free count is a popcount of invalid entries; no separate counter to drift.
  always_comb begin
    w_free_cnt = '0;
    for (int i = 0; i < N_MSHR; i++) begin
      if (!r_valid[i]) w_free_cnt = w_free_cnt + C_CNT_ONE;
    end
  end

  // Lowest-index free entry: scan downward so the last write wins.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_alloc_idx = MSHR_BITS'(i);
    end
  end

  assign w_full      = (w_free_cnt == '0);
  // Strobes are gated by rst so requests are ignored during reset.
  assign w_alloc_gnt = rst && alloc_req && !w_full;
  assign w_free_fire = rst && free_valid && w_free_in_range && r_valid[free_idx];
  // l2_regs gives add priority, so a release coinciding with a grant is deferred.
  assign w_incr      = rst && (w_free_fire || (r_pend_incr != '0)) && !w_alloc_gnt;

  // Allocation and release never target the same entry (one needs it
  // invalid, the other valid), so the order of these updates is irrelevant.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_free_fire) w_valid_nxt[free_idx] = 1'b0;
    if (w_alloc_gnt) w_valid_nxt[w_alloc_idx] = 1'b1;
  end

  // Parallel lookup against the current state; entries being freed still match.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_conflict = 1'b0;
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_set[i] == lookup_set)) begin
        if (r_tag[i] == lookup_tag) begin
          w_hit     = 1'b1;
          w_hit_idx = MSHR_BITS'(i);
        end else begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= '0;
      r_pend_incr <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_free_fire && !w_incr) begin
        r_pend_incr <= r_pend_incr + C_CNT_ONE;
      end else if (w_incr && !w_free_fire) begin
        r_pend_incr <= r_pend_incr - C_CNT_ONE;
      end
    end
  end

  // Tag/set payload has no reset; it is qualified by the valid bitmap.
  always_ff @(posedge clk) begin
    if (w_alloc_gnt) begin
      r_tag[w_alloc_idx] <= alloc_tag;
      r_set[w_alloc_idx] <= alloc_set;
    end
  end

  assign alloc_gnt             = w_alloc_gnt;
  assign alloc_idx             = w_alloc_idx;
  assign lookup_hit            = w_hit;
  assign lookup_hit_idx        = w_hit_idx;
  assign lookup_set_conflict   = w_conflict;
  assign add_mshr_entry        = w_alloc_gnt;
  assign incr_mshr_cnt         = w_incr;
  assign lmem_wr_en_clear_mshr = w_free_fire;
  assign mshr_i                = w_free_fire ? free_idx : '0;
  assign full                  = w_full;
  assign empty                 = (w_free_cnt == C_CNT_ALL);
  assign free_cnt              = w_free_cnt;

endmodule
`default_nettype wire

// File: tb/tb_l2_mshr_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_mshr_alloc
// Purpose  : Self-checking bench for l2_mshr_alloc. Directed scenarios plus
//            randomized traffic compared against an entry-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_mshr_alloc;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_req = 1'b0;
  logic [18:0] alloc_tag = '0;
  logic [8:0]  alloc_set = '0;
  logic        alloc_gnt;
  logic [3:0]  alloc_idx;
  logic        free_valid = 1'b0;
  logic [3:0]  free_idx = '0;
  logic [18:0] lookup_tag = '0;
  logic [8:0]  lookup_set = '0;
  logic        lookup_hit;
  logic [3:0]  lookup_hit_idx;
  logic        lookup_set_conflict;
  logic        add_mshr_entry;
  logic        incr_mshr_cnt;
  logic        lmem_wr_en_clear_mshr;
  logic [3:0]  mshr_i;
  logic        full;
  logic        empty;
  logic [4:0]  free_cnt;

  always #5 clk = ~clk;

  l2_mshr_alloc dut (
    .clk                   (clk),
    .rst                   (rst),
    .alloc_req             (alloc_req),
    .alloc_tag             (alloc_tag),
    .alloc_set             (alloc_set),
    .alloc_gnt             (alloc_gnt),
    .alloc_idx             (alloc_idx),
    .free_valid            (free_valid),
    .free_idx              (free_idx),
    .lookup_tag            (lookup_tag),
    .lookup_set            (lookup_set),
    .lookup_hit            (lookup_hit),
    .lookup_hit_idx        (lookup_hit_idx),
    .lookup_set_conflict   (lookup_set_conflict),
    .add_mshr_entry        (add_mshr_entry),
    .incr_mshr_cnt         (incr_mshr_cnt),
    .lmem_wr_en_clear_mshr (lmem_wr_en_clear_mshr),
    .mshr_i                (mshr_i),
    .full                  (full),
    .empty                 (empty),
    .free_cnt              (free_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one record per entry plus a count of unreported frees.
  bit          mv [N];
  logic [18:0] mt [N];
  logic [8:0]  ms [N];
  int          mpend;

  bit e_gnt, e_ff, e_incr, e_hit, e_conf, e_full, e_empty;
  int e_idx, e_hidx, e_fcnt, e_mshr_i;

  task automatic model_reset();
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
    mpend = 0;
  endtask

  task automatic model_eval();
    int  cnt;
    bit  found;
    cnt = 0;
    for (int i = 0; i < N; i++) if (!mv[i]) cnt++;
    e_fcnt  = cnt;
    e_full  = (cnt == 0);
    e_empty = (cnt == N);
    e_idx   = 0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!mv[i] && !found) begin e_idx = i; found = 1'b1; end
    end
    e_gnt    = rst && alloc_req && (cnt > 0);
    e_ff     = rst && free_valid && mv[free_idx];
    e_incr   = rst && (e_ff || mpend > 0) && !e_gnt;
    e_mshr_i = e_ff ? int'(free_idx) : 0;
    e_hit = 1'b0; e_hidx = 0; e_conf = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mv[i] && ms[i] == lookup_set) begin
        if (mt[i] == lookup_tag) begin
          if (!e_hit) begin e_hit = 1'b1; e_hidx = i; end
        end else begin
          e_conf = 1'b1;
        end
      end
    end
  endtask

  task automatic model_commit();
    if (e_ff) mv[free_idx] = 1'b0;
    if (e_gnt) begin mv[e_idx] = 1'b1; mt[e_idx] = alloc_tag; ms[e_idx] = alloc_set; end
    if (e_ff && !e_incr) mpend++;
    else if (e_incr && !e_ff) mpend--;
  endtask

  // Called at posedge+1; drives inputs and evaluates the model at posedge+3.
  task automatic apply(input bit req, input logic [18:0] at, input logic [8:0] aset,
                       input bit fv, input logic [3:0] fi,
                       input logic [18:0] lt, input logic [8:0] ls);
    alloc_req = req; alloc_tag = at; alloc_set = aset;
    free_valid = fv; free_idx = fi; lookup_tag = lt; lookup_set = ls;
    #2;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    alloc_req = 1'b0; free_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    alloc_req = 1'b1; free_valid = 1'b1; free_idx = 4'd0;
    @(posedge clk); #1;
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    n_tests++; if (free_cnt !== 5'd16) begin n_fail++; $display("FAIL reset_free_cnt: got %0d expected 16", free_cnt); end
    n_tests++; if (alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %0b expected 0", alloc_gnt); end
    n_tests++; if (incr_mshr_cnt !== 1'b0 || lmem_wr_en_clear_mshr !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: got incr=%0b clr=%0b expected 0 0", incr_mshr_cnt, lmem_wr_en_clear_mshr);
    end
    alloc_req = 1'b0; free_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < N; i++) begin
      apply(1'b1, 19'h100 + 19'(i), 9'd5, 1'b0, 4'd0, 19'd0, 9'd0);
      n_tests++; if (alloc_gnt !== 1'b1 || alloc_idx !== 4'(i)) begin
        n_fail++; $display("FAIL fill_grant[%0d]: got gnt=%0b idx=%0d expected 1 %0d", i, alloc_gnt, alloc_idx, i);
      end
      tick();
    end
    apply(1'b1, 19'h111, 9'd5, 1'b0, 4'd0, 19'h10A, 9'd5);
    n_tests++; if (full !== 1'b1 || free_cnt !== 5'd0) begin
      n_fail++; $display("FAIL fill_full: got full=%0b cnt=%0d expected 1 0", full, free_cnt);
    end
    n_tests++; if (alloc_gnt !== 1'b0 || add_mshr_entry !== 1'b0) begin
      n_fail++; $display("FAIL fill_17th_gnt: got gnt=%0b add=%0b expected 0 0", alloc_gnt, add_mshr_entry);
    end
    n_tests++; if (lookup_hit !== 1'b1 || lookup_hit_idx !== 4'd10 || lookup_set_conflict !== 1'b1) begin
      n_fail++; $display("FAIL fill_lookup: got hit=%0b idx=%0d conf=%0b expected 1 10 1",
                         lookup_hit, lookup_hit_idx, lookup_set_conflict);
    end
    tick();
  endtask

  // Starts from the full state left by test_fill.
  task automatic test_full_free();
    apply(1'b1, 19'h200, 9'd6, 1'b1, 4'd7, 19'd0, 9'd0);
    n_tests++; if (alloc_gnt !== 1'b0 || incr_mshr_cnt !== 1'b1) begin
      n_fail++; $display("FAIL fullfree_same: got gnt=%0b incr=%0b expected 0 1", alloc_gnt, incr_mshr_cnt);
    end
    n_tests++; if (lmem_wr_en_clear_mshr !== 1'b1 || mshr_i !== 4'd7) begin
      n_fail++; $display("FAIL fullfree_clear: got clr=%0b mshr_i=%0d expected 1 7", lmem_wr_en_clear_mshr, mshr_i);
    end
    tick();
    apply(1'b1, 19'h200, 9'd6, 1'b0, 4'd0, 19'd0, 9'd0);
    n_tests++; if (alloc_gnt !== 1'b1 || alloc_idx !== 4'd7 || free_cnt !== 5'd1) begin
      n_fail++; $display("FAIL fullfree_next: got gnt=%0b idx=%0d cnt=%0d expected 1 7 1", alloc_gnt, alloc_idx, free_cnt);
    end
    n_tests++; if (incr_mshr_cnt !== 1'b0) begin n_fail++; $display("FAIL fullfree_noincr: got %0b expected 0", incr_mshr_cnt); end
    tick();
  endtask

  task automatic test_pend();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 19'h300 + 19'(i), 9'd2, 1'b0, 4'd0, 19'd0, 9'd0);
      tick();
    end
    apply(1'b0, 19'd0, 9'd0, 1'b1, 4'd1, 19'd0, 9'd0);
    n_tests++; if (incr_mshr_cnt !== 1'b1 || mshr_i !== 4'd1) begin
      n_fail++; $display("FAIL pend_plain_free: got incr=%0b mshr_i=%0d expected 1 1", incr_mshr_cnt, mshr_i);
    end
    tick();
    // Entries 0 and 2 valid: allocate (gets 1) and free 2 together.
    apply(1'b1, 19'h333, 9'd2, 1'b1, 4'd2, 19'd0, 9'd0);
    n_tests++; if (add_mshr_entry !== 1'b1 || alloc_idx !== 4'd1 || incr_mshr_cnt !== 1'b0) begin
      n_fail++; $display("FAIL pend_combo: got add=%0b idx=%0d incr=%0b expected 1 1 0", add_mshr_entry, alloc_idx, incr_mshr_cnt);
    end
    n_tests++; if (lmem_wr_en_clear_mshr !== 1'b1 || free_cnt !== 5'd14) begin
      n_fail++; $display("FAIL pend_combo_clr: got clr=%0b cnt=%0d expected 1 14", lmem_wr_en_clear_mshr, free_cnt);
    end
    tick();
    apply(1'b0, 19'd0, 9'd0, 1'b0, 4'd0, 19'd0, 9'd0);
    n_tests++; if (incr_mshr_cnt !== 1'b1 || lmem_wr_en_clear_mshr !== 1'b0 || mshr_i !== 4'd0 || free_cnt !== 5'd14) begin
      n_fail++; $display("FAIL pend_drain: got incr=%0b clr=%0b mshr_i=%0d cnt=%0d expected 1 0 0 14",
                         incr_mshr_cnt, lmem_wr_en_clear_mshr, mshr_i, free_cnt);
    end
    tick();
    apply(1'b0, 19'd0, 9'd0, 1'b0, 4'd0, 19'd0, 9'd0);
    n_tests++; if (incr_mshr_cnt !== 1'b0) begin n_fail++; $display("FAIL pend_empty: got %0b expected 0", incr_mshr_cnt); end
    tick();
  endtask

  task automatic test_lookup();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 19'h1 + 19'(i), 9'd1, 1'b0, 4'd0, 19'd0, 9'd0);
      tick();
    end
    apply(1'b1, 19'hABC, 9'd9, 1'b0, 4'd0, 19'd0, 9'd0);
    n_tests++; if (alloc_idx !== 4'd3) begin n_fail++; $display("FAIL lookup_setup_idx: got %0d expected 3", alloc_idx); end
    tick();
    apply(1'b0, 19'd0, 9'd0, 1'b0, 4'd0, 19'hABC, 9'd9);
    n_tests++; if (lookup_hit !== 1'b1 || lookup_hit_idx !== 4'd3 || lookup_set_conflict !== 1'b0) begin
      n_fail++; $display("FAIL lookup_hit: got hit=%0b idx=%0d conf=%0b expected 1 3 0", lookup_hit, lookup_hit_idx, lookup_set_conflict);
    end
    lookup_tag = 19'hABD; #1;
    n_tests++; if (lookup_hit !== 1'b0 || lookup_hit_idx !== 4'd0 || lookup_set_conflict !== 1'b1) begin
      n_fail++; $display("FAIL lookup_conflict: got hit=%0b idx=%0d conf=%0b expected 0 0 1", lookup_hit, lookup_hit_idx, lookup_set_conflict);
    end
    lookup_tag = 19'hABC; lookup_set = 9'd8; #1;
    n_tests++; if (lookup_hit !== 1'b0 || lookup_set_conflict !== 1'b0) begin
      n_fail++; $display("FAIL lookup_miss: got hit=%0b conf=%0b expected 0 0", lookup_hit, lookup_set_conflict);
    end
    tick();
    apply(1'b0, 19'd0, 9'd0, 1'b1, 4'd3, 19'hABC, 9'd9);
    n_tests++; if (lookup_hit !== 1'b1 || lookup_hit_idx !== 4'd3 || lmem_wr_en_clear_mshr !== 1'b1) begin
      n_fail++; $display("FAIL lookup_while_free: got hit=%0b idx=%0d clr=%0b expected 1 3 1", lookup_hit, lookup_hit_idx, lmem_wr_en_clear_mshr);
    end
    tick();
    apply(1'b0, 19'd0, 9'd0, 1'b0, 4'd0, 19'hABC, 9'd9);
    n_tests++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_after_free: got %0b expected 0", lookup_hit); end
    tick();
  endtask

  // Entries 0..2 valid from test_lookup; entry 4 has never been allocated.
  task automatic test_invalid_free();
    apply(1'b0, 19'd0, 9'd0, 1'b1, 4'd4, 19'd0, 9'd0);
    n_tests++; if (lmem_wr_en_clear_mshr !== 1'b0 || incr_mshr_cnt !== 1'b0 || mshr_i !== 4'd0) begin
      n_fail++; $display("FAIL invfree_strobes: got clr=%0b incr=%0b mshr_i=%0d expected 0 0 0",
                         lmem_wr_en_clear_mshr, incr_mshr_cnt, mshr_i);
    end
    tick();
    apply(1'b0, 19'd0, 9'd0, 1'b0, 4'd0, 19'd0, 9'd0);
    n_tests++; if (free_cnt !== 5'd13) begin n_fail++; $display("FAIL invfree_cnt: got %0d expected 13", free_cnt); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      apply(($urandom % 10) < 6, 19'h100 + 19'($urandom % 8), 9'($urandom % 4),
            ($urandom % 2) == 1, 4'($urandom), 19'h100 + 19'($urandom % 8), 9'($urandom % 4));
      n_tests++; if (alloc_gnt !== e_gnt || add_mshr_entry !== e_gnt) begin
        n_fail++; $display("FAIL rnd_gnt[%0d]: got gnt=%0b add=%0b expected %0b", c, alloc_gnt, add_mshr_entry, e_gnt);
      end
      n_tests++; if (alloc_idx !== 4'(e_idx)) begin n_fail++; $display("FAIL rnd_idx[%0d]: got %0d expected %0d", c, alloc_idx, e_idx); end
      n_tests++; if (incr_mshr_cnt !== e_incr) begin n_fail++; $display("FAIL rnd_incr[%0d]: got %0b expected %0b", c, incr_mshr_cnt, e_incr); end
      n_tests++; if (lmem_wr_en_clear_mshr !== e_ff || mshr_i !== 4'(e_mshr_i)) begin
        n_fail++; $display("FAIL rnd_clear[%0d]: got clr=%0b mshr_i=%0d expected %0b %0d", c, lmem_wr_en_clear_mshr, mshr_i, e_ff, e_mshr_i);
      end
      n_tests++; if (free_cnt !== 5'(e_fcnt) || full !== e_full || empty !== e_empty) begin
        n_fail++; $display("FAIL rnd_occ[%0d]: got cnt=%0d full=%0b empty=%0b expected %0d %0b %0b",
                           c, free_cnt, full, empty, e_fcnt, e_full, e_empty);
      end
      n_tests++; if (lookup_hit !== e_hit || lookup_hit_idx !== 4'(e_hidx) || lookup_set_conflict !== e_conf) begin
        n_fail++; $display("FAIL rnd_lookup[%0d]: got hit=%0b idx=%0d conf=%0b expected %0b %0d %0b",
                           c, lookup_hit, lookup_hit_idx, lookup_set_conflict, e_hit, e_hidx, e_conf);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 19'h400 + 19'(i), 9'd3, 1'b0, 4'd0, 19'd0, 9'd0);
      tick();
    end
    apply(1'b1, 19'h405, 9'd3, 1'b1, 4'd0, 19'd0, 9'd0);
    tick();
    apply(1'b1, 19'h406, 9'd3, 1'b1, 4'd1, 19'd0, 9'd0);
    n_tests++; if (alloc_idx !== 4'd0 || incr_mshr_cnt !== 1'b0) begin
      n_fail++; $display("FAIL arst_setup: got idx=%0d incr=%0b expected 0 0", alloc_idx, incr_mshr_cnt);
    end
    tick();
    // Five entries valid, two releases pending.
    apply(1'b0, 19'd0, 9'd0, 1'b0, 4'd0, 19'h402, 9'd3);
    n_tests++; if (incr_mshr_cnt !== 1'b1 || free_cnt !== 5'd11 || lookup_hit !== 1'b1) begin
      n_fail++; $display("FAIL arst_before: got incr=%0b cnt=%0d hit=%0b expected 1 11 1", incr_mshr_cnt, free_cnt, lookup_hit);
    end
    alloc_req = 1'b1; free_valid = 1'b1; free_idx = 4'd2;
    #1 rst = 1'b0;
    model_reset();
    #1;
    n_tests++; if (full !== 1'b0 || empty !== 1'b1 || free_cnt !== 5'd16) begin
      n_fail++; $display("FAIL arst_occ: got full=%0b empty=%0b cnt=%0d expected 0 1 16", full, empty, free_cnt);
    end
    n_tests++; if (alloc_gnt !== 1'b0 || incr_mshr_cnt !== 1'b0 || lmem_wr_en_clear_mshr !== 1'b0 || mshr_i !== 4'd0) begin
      n_fail++; $display("FAIL arst_strobes: got gnt=%0b incr=%0b clr=%0b mshr_i=%0d expected 0 0 0 0",
                         alloc_gnt, incr_mshr_cnt, lmem_wr_en_clear_mshr, mshr_i);
    end
    n_tests++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL arst_lookup: got %0b expected 0", lookup_hit); end
    alloc_req = 1'b0; free_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    apply(1'b0, 19'd0, 9'd0, 1'b0, 4'd0, 19'd0, 9'd0);
    n_tests++; if (incr_mshr_cnt !== 1'b0 || free_cnt !== 5'd16) begin
      n_fail++; $display("FAIL arst_after: got incr=%0b cnt=%0d expected 0 16", incr_mshr_cnt, free_cnt);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_full_free();
    test_pend();
    test_lookup();
    test_invalid_free();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
